// File: rtl/fifo_advanced_pkg.sv
// Shared sizing helpers and the pointer wrap function for fifo_advanced.
// These helpers are used by fifo_advanced and wrapping_counter.
package fifo_advanced_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Modulo-depth increment; depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_advanced_wrapping_counter.sv
// Modulo-DEPTH pointer: counts 0..DEPTH-1 and wraps to 0.
// The clear input takes priority over the increment input.
module wrapping_counter
  import fifo_advanced_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        increment,
  output logic [ptr_width(DEPTH)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (increment)
      count <= PW'(wrap_inc(32'(count), DEPTH));
  end

endmodule

// File: rtl/fifo_advanced.sv
// First-word-fall-through FIFO with any depth, a registered fill level, threshold flags and flush.
// Define FIFO_ADVANCED_ERROR_FLAGS_EN to add the sticky overflow and underflow flags.
module fifo_advanced
  import fifo_advanced_pkg::*;
#(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 4,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          write_enable,
  input  logic [WIDTH-1:0]              write_data,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          read_enable,
  output logic [WIDTH-1:0]              read_data,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level
`ifdef FIFO_ADVANCED_ERROR_FLAGS_EN
  ,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clear_errors
`endif
);

  localparam int LW = level_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL_THRESHOLD);
  localparam logic [LW-1:0] AE_LVL   = LW'(ALMOST_EMPTY_THRESHOLD);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_accept;
  logic             rd_accept;

  assign full         = (level == FULL_LVL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // A full FIFO still takes a write when the same cycle frees the head slot.
  assign wr_accept = write_enable && (!full || read_enable);
  assign rd_accept = read_enable && !empty;

  // Gating with empty keeps read_data at zero out of reset, since storage is not reset.
  assign read_data = empty ? '0 : mem[rd_ptr];

  wrapping_counter #(.DEPTH(DEPTH)) u_wr_ptr (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .increment (wr_accept),
    .count     (wr_ptr)
  );

  wrapping_counter #(.DEPTH(DEPTH)) u_rd_ptr (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .increment (rd_accept),
    .count     (rd_ptr)
  );

  always_ff @(posedge clock) begin
    if (wr_accept && !flush)
      mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      level <= '0;
    else if (flush)
      level <= '0;
    else if (wr_accept && !rd_accept)
      level <= level + LW'(1);
    else if (rd_accept && !wr_accept)
      level <= level - LW'(1);
  end

`ifdef FIFO_ADVANCED_ERROR_FLAGS_EN
  // A set event in the same cycle as clear_errors wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && full && !read_enable)
        overflow <= 1'b1;
      else if (clear_errors)
        overflow <= 1'b0;
      if (read_enable && empty)
        underflow <= 1'b1;
      else if (clear_errors)
        underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_advanced.sv
// Scoreboard bench for fifo_advanced (DEPTH=5, AF=4, AE=1): stimulus queues expected words,
// a negedge monitor pops and compares them on every accepted read.
module tb_fifo_advanced;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] write_data = '0;
  logic       read_enable = 1'b0;
  logic       full, almost_full, empty, almost_empty;
  logic [7:0] read_data;
  logic [2:0] level;
`ifdef FIFO_ADVANCED_ERROR_FLAGS_EN
  logic       overflow, underflow;
  logic       clear_errors = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  fifo_advanced #(
    .WIDTH(8), .DEPTH(5), .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .write_enable (write_enable),
    .write_data   (write_data),
    .full         (full),
    .almost_full  (almost_full),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level)
`ifdef FIFO_ADVANCED_ERROR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow),
    .clear_errors (clear_errors)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A read takes the head only when the model holds data and no flush is pending.
  always @(negedge clock) begin
    if (!reset && !flush && read_enable && exp_q.size() > 0) begin
      check("read_data", int'(read_data), int'(exp_q[0]));
      void'(exp_q.pop_front());
    end
  end

  // Drive one cycle; push is the hand-decided "this write is accepted".
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re,
                       input logic fl, input logic push);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    flush        = fl;
    @(posedge clock);
    if (fl) exp_q.delete();
    else if (push) exp_q.push_back(wd);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int lvl, input logic e, input logic ae,
                             input logic af, input logic f);
    check({tag, " level"}, int'(level), lvl);
    check({tag, " empty"}, int'(empty), int'(e));
    check({tag, " almost_empty"}, int'(almost_empty), int'(ae));
    check({tag, " almost_full"}, int'(almost_full), int'(af));
    check({tag, " full"}, int'(full), int'(f));
  endtask

  initial begin
    #12;
    check_flags("reset", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset read_data", int'(read_data), 0);
`ifdef FIFO_ADVANCED_ERROR_FLAGS_EN
    check("reset overflow", int'(overflow), 0);
    check("reset underflow", int'(underflow), 0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    // Fill to full: 0x11..0x15
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      check_flags("fill", i, 1'b0, i <= 1, i >= 4, i == 5);
    end
    cycle(1'b1, 8'h16, 1'b0, 1'b0, 1'b0);
    check_flags("drop", 5, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef FIFO_ADVANCED_ERROR_FLAGS_EN
    check("overflow set", int'(overflow), 1);
    clear_errors = 1'b1;
    @(posedge clock); #1;
    clear_errors = 1'b0;
    check("overflow cleared", int'(overflow), 0);
`endif

    // Drain: monitor expects 0x11..0x15
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check_flags("drain", 5 - i, i == 5, i >= 4, i <= 1, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_flags("underread", 0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef FIFO_ADVANCED_ERROR_FLAGS_EN
    check("underflow set", int'(underflow), 1);
`endif

    // Streaming write+read: level held at 1, pointers wrap at 5
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 8'(i + 8'h60), 1'b1, 1'b0, 1'b1);
      check("stream level", int'(level), 1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("stream drained", int'(level), 0);

    // Full plus simultaneous write+read
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1);
    check("prefull level", int'(level), 5);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
    check_flags("full wr+rd", 5, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("after AA drain", int'(level), 0);

    // Flush wins over a same-cycle write
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    check("preflush level", int'(level), 3);
    cycle(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
    check_flags("flush", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h35, 1'b0, 1'b0, 1'b1);
    check("post-flush head", int'(read_data), 8'h35);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    check("prereset level", int'(level), 3);
    #2;
    reset = 1'b1;
    #1;
    check_flags("async reset", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    #1;
    reset = 1'b0;
    cycle(1'b1, 8'h51, 1'b0, 1'b0, 1'b1);
    check("post-reset level", int'(level), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("post-reset empty", int'(empty), 1);
    check("model drained", exp_q.size(), 0);

    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_advanced.md
Name: fifo_advanced

Overview:
Parametrised successor to the basic read/write-enable FIFO in the data building blocks.
- Adds arbitrary (non-power-of-2) depth, a fill-level output, programmable almost-full/almost-empty thresholds, synchronous flush, and write-while-full when a read occurs in the same cycle.
- Head-of-queue data is presented combinationally (first-word-fall-through).
- Used as the general-purpose buffer between pipeline stages that need early back-pressure.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of entries (>=2, any integer, need not be a power of 2)
ALMOST_FULL_THRESHOLD, DEPTH-1, almost_full asserted when level >= this value (1..DEPTH)
ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserted when level <= this value (0..DEPTH-1)

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all entries
write_enable  input  1  push write_data this cycle
write_data  input  WIDTH  data to push
full  output  1  level == DEPTH
almost_full  output  1  level >= ALMOST_FULL_THRESHOLD
read_enable  input  1  pop head this cycle
read_data  output  WIDTH  current head entry, valid while !empty
empty  output  1  level == 0
almost_empty  output  1  level <= ALMOST_EMPTY_THRESHOLD
level  output  $clog2(DEPTH+1)  number of stored entries

Behaviour:
- Reset (asynchronous, active-high): pointers = 0, level = 0. Outputs: empty=1, almost_empty=1, full=0, almost_full=0, level=0, read_data=0. Storage contents are not reset.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage: DEPTH-entry register array.
  - Read and write pointers count 0..DEPTH-1 and wrap to 0 after DEPTH-1. No power-of-2 masking.
  - level is a registered counter, not derived from pointer difference.
- Status flags are combinational from the registered level and reflect state after the last edge.
- read_data = mem[read_pointer] combinationally. A written word appears on read_data the cycle after its write edge (1-cycle write-to-read latency). No same-cycle bypass.
- Accepted write: write_enable && (!full || read_enable). Writes mem[write_pointer], advances write_pointer.
- Accepted read: read_enable && !empty. Advances read_pointer.
- Both accepted in the same cycle: level unchanged.
  - Full plus write plus read: writes into the slot being vacated. Data order is preserved.
  - Empty plus write plus read: read is ignored and the write is accepted, so level becomes 1.
- Write when full without read: dropped, no state change.
- Read when empty: ignored. read_data is don't-care.
- flush=1 at an edge: pointers return to 0 and level to 0. flush has priority over any write/read in the same cycle; those are discarded.
- Level arithmetic: level_next = level + accepted_write - accepted_read, never outside 0..DEPTH.

Optional Feature:
Macro FIFO_ADVANCED_ERROR_FLAGS_EN.
- When defined, adds three ports:
  - overflow (output 1): sticky, set on a dropped write.
  - underflow (output 1): sticky, set on a read when empty.
  - clear_errors (input 1): synchronous, clears both flags; a set event in the same cycle wins.
- Both flags reset to 0 and are unaffected by flush.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package fifo_advanced_pkg holds:
  - localparam function for level width ($clog2(DEPTH+1))
  - pointer width ($clog2(DEPTH))
  - pointer-increment-with-wrap function
- One natural sub-module, wrapping_counter: modulo-DEPTH pointer with increment and clear inputs. Instantiated twice, for the read and write pointers.

Test Plan:
- DEPTH=5, ALMOST_FULL_THRESHOLD=4, ALMOST_EMPTY_THRESHOLD=1.
  - Reset, then 5 single writes 0x11..0x15: level goes 1..5; almost_empty drops after 2nd write; almost_full at 4th; full at 5th. 6th write 0x16 is dropped, level stays 5, and overflow=1 with the macro defined.
  - From full, 5 reads: read_data 0x11..0x15 in order; empty and level=0 after the 5th. A further read leaves level=0 and sets underflow=1.
  - 100 cycles of write+read back-to-back with incrementing data: level stays 1 after the first cycle, no data mismatch, and pointers wrap at 5 (non-power-of-2) without error.
  - Full, then write 0xAA with read in the same cycle: read returns the old head, level stays 5, and 0xAA emerges 5th in order.
  - Level 3, then flush together with write_enable: next cycle level=0, empty=1, and the written word never appears.
  - Level 3, then reset pulse asserted between edges: empty=1 and level=0 immediately. The next write/read works normally.
